// File: rtl/dlx_pkg.sv
// Shared definitions for the DLX ID stage.
// Contents: opcode constants, control-vector widths, bit positions within
// each control vector, and a decode helper. The helper maps an opcode onto
// its control fields and its operand-use flags.
package dlx_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam int EX_W = 4;
  localparam int M_W  = 2;
  localparam int WB_W = 2;

  // EX_control = {reg_dst, alu_src, alu_op[1:0]}
  localparam int EX_REG_DST   = 3;
  localparam int EX_ALU_SRC   = 2;
  localparam int EX_ALU_OP_HI = 1;
  // M_control = {mem_read, mem_write}
  localparam int M_MEM_READ   = 1;
  localparam int M_MEM_WRITE  = 0;
  // WB_control = {reg_write, mem_to_reg}
  localparam int WB_REG_WRITE  = 1;
  localparam int WB_MEM_TO_REG = 0;

  typedef struct packed {
    logic [EX_W-1:0] ex;
    logic [M_W-1:0]  m;
    logic [WB_W-1:0] wb;
    logic            uses_rt;
    logic            is_branch;  // beq or bne
    logic            is_bne;
    logic            is_jump;
  } dec_t;

  // Unknown opcodes fall through to all-zero controls, which is a NOP.
  // Branches and jumps carry no EX/M/WB controls into the pipeline.
  function automatic dec_t decode_op(input logic [5:0] op);
    dec_t d;
    d = '0;
    case (op)
      OP_RTYPE: begin
        d.ex[EX_REG_DST]    = 1'b1;
        d.ex[EX_ALU_OP_HI]  = 1'b1;
        d.wb[WB_REG_WRITE]  = 1'b1;
        d.uses_rt           = 1'b1;
      end
      OP_LW: begin
        d.ex[EX_ALU_SRC]    = 1'b1;
        d.m[M_MEM_READ]     = 1'b1;
        d.wb[WB_REG_WRITE]  = 1'b1;
        d.wb[WB_MEM_TO_REG] = 1'b1;
      end
      OP_SW: begin
        d.ex[EX_ALU_SRC]    = 1'b1;
        d.m[M_MEM_WRITE]    = 1'b1;
        d.uses_rt           = 1'b1;
      end
      OP_ADDI: begin
        d.ex[EX_ALU_SRC]    = 1'b1;
        d.wb[WB_REG_WRITE]  = 1'b1;
      end
      OP_BEQ: begin
        d.is_branch = 1'b1;
        d.uses_rt   = 1'b1;
      end
      OP_BNE: begin
        d.is_branch = 1'b1;
        d.is_bne    = 1'b1;
        d.uses_rt   = 1'b1;
      end
      OP_J: d.is_jump = 1'b1;
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/reg_bank_2r1w.sv
// Two-read / one-write register bank.
// Ports: clock, reset (async, active-high, clears every register);
//   we/waddr/wdata write port; raddr_a/raddr_b -> rdata_a/rdata_b reads.
// Register 0 reads as zero and ignores writes. A read of the register being
// written in the same cycle returns the incoming wdata (write-through).
module reg_bank_2r1w #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  localparam int RA_W    = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [RA_W-1:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RA_W-1:0]   raddr_a,
  input  logic [RA_W-1:0]   raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (we && waddr != '0 && int'(waddr) < NUM_REGS) regs_d[waddr] = wdata;
    regs_d[0] = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    rdata_a = '0;
    if (raddr_a != '0) begin
      if (we && waddr == raddr_a) rdata_a = wdata;
      else                        rdata_a = regs_q[raddr_a];
    end
  end

  always_comb begin
    rdata_b = '0;
    if (raddr_b != '0) begin
      if (we && waddr == raddr_b) rdata_b = wdata;
      else                        rdata_b = regs_q[raddr_b];
    end
  end

endmodule

// File: rtl/pipelined_decode.sv
// ID stage of the 5-stage DLX pipeline, including the ID/EX register.
// Inputs: clock, reset (async, active-high); id_valid/instruc/current_PC
//   from IF/ID; WB write port (wb_reg_write/rw/busw); EX-stage occupant
//   (ex_mem_read/ex_reg_write/ex_rd); MEM-stage occupant (mem_mem_read/
//   mem_reg_write/mem_rd/mem_result).
// Combinational outputs: stall, pc_sel, target_pc.
// Registered outputs: EX/M/WB controls, bus_a/bus_b/immed_ext, rs_q/rt_q/
//   rd_q, ex_valid.
// ex_valid qualifies the ID/EX slot: when it is 0 every registered output
// is 0 and EX must treat the slot as a bubble. There is no back-pressure
// from EX; the register updates every cycle.
module pipelined_decode
  import dlx_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int PC_W     = 10,
  parameter int NUM_REGS = 32,
  localparam int RA_W    = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [31:0]       instruc,
  input  logic [PC_W-1:0]   current_PC,
  input  logic              wb_reg_write,
  input  logic [RA_W-1:0]   rw,
  input  logic [DATA_W-1:0] busw,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic [RA_W-1:0]   ex_rd,
  input  logic              mem_mem_read,
  input  logic              mem_reg_write,
  input  logic [RA_W-1:0]   mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  output logic              stall,
  output logic              pc_sel,
  output logic [PC_W-1:0]   target_pc,
  output logic [EX_W-1:0]   EX_control,
  output logic [M_W-1:0]    M_control,
  output logic [WB_W-1:0]   WB_control,
  output logic [DATA_W-1:0] bus_a,
  output logic [DATA_W-1:0] bus_b,
  output logic [DATA_W-1:0] immed_ext,
  output logic [RA_W-1:0]   rs_q,
  output logic [RA_W-1:0]   rt_q,
  output logic [RA_W-1:0]   rd_q,
  output logic              ex_valid
);

  typedef struct packed {
    logic              valid;
    logic [EX_W-1:0]   ex;
    logic [M_W-1:0]    m;
    logic [WB_W-1:0]   wb;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;
    logic [RA_W-1:0]   rs;
    logic [RA_W-1:0]   rt;
    logic [RA_W-1:0]   rd;
  } idex_t;

  logic [RA_W-1:0]   rs, rt, rd;
  logic [DATA_W-1:0] rd_a, rd_b, br_a, br_b, imm_ext;
  dec_t              dec;
  logic              load_use, br_ex_hz, br_mem_hz, taken, bubble;
  idex_t             idex_d, idex_q;

  assign rs      = instruc[21 +: RA_W];
  assign rt      = instruc[16 +: RA_W];
  assign rd      = instruc[11 +: RA_W];
  assign dec     = decode_op(instruc[31:26]);
  assign imm_ext = {{(DATA_W-16){instruc[15]}}, instruc[15:0]};

  reg_bank_2r1w #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_bank (
    .clock   (clock),
    .reset   (reset),
    .we      (wb_reg_write),
    .waddr   (rw),
    .wdata   (busw),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  // Branch comparator may take a finished ALU result from MEM. A load in
  // MEM has no data yet, so it is excluded here and handled as a stall.
  always_comb begin
    br_a = rd_a;
    br_b = rd_b;
    if (mem_reg_write && !mem_mem_read && mem_rd == rs && rs != '0) br_a = mem_result;
    if (mem_reg_write && !mem_mem_read && mem_rd == rt && rt != '0) br_b = mem_result;
  end

  always_comb begin
    load_use  = ex_mem_read && ex_rd != '0 &&
                (ex_rd == rs || (dec.uses_rt && ex_rd == rt));
    br_ex_hz  = dec.is_branch && ex_reg_write && ex_rd != '0 &&
                (ex_rd == rs || ex_rd == rt);
    br_mem_hz = dec.is_branch && mem_mem_read && mem_rd != '0 &&
                (mem_rd == rs || mem_rd == rt);
    // Reset drops any pending stall so fetch is not held while flushing.
    stall     = id_valid && !reset && (load_use || br_ex_hz || br_mem_hz);
  end

  always_comb begin
    taken = dec.is_jump;
    if (dec.is_branch) taken = dec.is_bne ? (br_a != br_b) : (br_a == br_b);
    pc_sel    = id_valid && !stall && taken;
    // Branch offset is truncated to PC_W so the sum wraps.
    target_pc = dec.is_jump ? instruc[PC_W-1:0] : current_PC + instruc[PC_W-1:0];
  end

  assign bubble = stall || !id_valid;

  always_comb begin
    idex_d = '0;
    if (!bubble) begin
      idex_d.valid = 1'b1;
      idex_d.ex    = dec.ex;
      idex_d.m     = dec.m;
      idex_d.wb    = dec.wb;
      idex_d.a     = rd_a;
      idex_d.b     = rd_b;
      idex_d.imm   = imm_ext;
      idex_d.rs    = rs;
      idex_d.rt    = rt;
      idex_d.rd    = rd;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) idex_q <= '0;
    else       idex_q <= idex_d;
  end

  assign ex_valid   = idex_q.valid;
  assign EX_control = idex_q.ex;
  assign M_control  = idex_q.m;
  assign WB_control = idex_q.wb;
  assign bus_a      = idex_q.a;
  assign bus_b      = idex_q.b;
  assign immed_ext  = idex_q.imm;
  assign rs_q       = idex_q.rs;
  assign rt_q       = idex_q.rt;
  assign rd_q       = idex_q.rd;

endmodule
